wb_regfile: RTL and testbench

Write-back stage and architectural register file for the 5-stage pipeline. It consumes the MEM/WB pipeline register outputs and selects the write-back value (memory load data or ALU result). It commits that value to a 2^ADDR_W × DATA_W register file and serves the two ID-stage read ports. It also exports the selected write-back value for EX-stage forwarding and keeps a retired-write counter.

---
 rtl/wb_regfile.sv | 63 ++++++
 tb/tb_wb_regfile.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and architectural register file.
// Selects the write-back value (load data or ALU result), commits it to a
// 2^ADDR_W x DATA_W register file with r0 hardwired to zero, serves two
// asynchronous ID-stage read ports, exports the write-back value for
// forwarding and counts retired register writes.
// Optional feature: define WB_REGFILE_BYPASS_EN to make a read of the register
// being committed in the same cycle return the new value (write-through).
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] ALU_Result,
  input  logic [ADDR_W-1:0] Write_Destination,
  input  logic [ADDR_W-1:0] Read_Reg1,
  input  logic [ADDR_W-1:0] Read_Reg2,
  output logic [DATA_W-1:0] Read_Data1,
  output logic [DATA_W-1:0] Read_Data2,
  output logic [DATA_W-1:0] WB_Data,
  output logic              WB_Valid,
  output logic [31:0]       Retire_Count
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              commit;

  // Write-back select and commit qualification (writes to r0 are discarded)
  always_comb begin
    WB_Data  = MemtoReg ? ReadData : ALU_Result;
    commit   = RegWrite && (Write_Destination != '0);
    WB_Valid = commit;
  end

  // Register array and retire counter; reset wins over a simultaneous commit
  always_ff @(posedge clk) begin
    if (rst) begin
      regs         <= '{default: '0};
      Retire_Count <= '0;
    end else if (commit) begin
      regs[Write_Destination] <= WB_Data;
      Retire_Count            <= Retire_Count + 32'd1;
    end
  end

  // Asynchronous read ports; r0 always reads zero
  always_comb begin
    Read_Data1 = regs[Read_Reg1];
    Read_Data2 = regs[Read_Reg2];
`ifdef WB_REGFILE_BYPASS_EN
    if (commit && (Read_Reg1 == Write_Destination)) Read_Data1 = WB_Data;
    if (commit && (Read_Reg2 == Write_Destination)) Read_Data2 = WB_Data;
`endif
    if (Read_Reg1 == '0) Read_Data1 = '0;
    if (Read_Reg2 == '0) Read_Data2 = '0;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: directed vectors, expected values pushed to a
// scoreboard queue by the driver and compared by a monitor at each falling edge.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite;
  logic        MemtoReg;
  logic [31:0] ReadData;
  logic [31:0] ALU_Result;
  logic [4:0]  Write_Destination;
  logic [4:0]  Read_Reg1;
  logic [4:0]  Read_Reg2;
  logic [31:0] Read_Data1;
  logic [31:0] Read_Data2;
  logic [31:0] WB_Data;
  logic        WB_Valid;
  logic [31:0] Retire_Count;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ReadData(ReadData), .ALU_Result(ALU_Result),
    .Write_Destination(Write_Destination),
    .Read_Reg1(Read_Reg1), .Read_Reg2(Read_Reg2),
    .Read_Data1(Read_Data1), .Read_Data2(Read_Data2),
    .WB_Data(WB_Data), .WB_Valid(WB_Valid), .Retire_Count(Retire_Count)
  );

  always #5 clk = ~clk;

  // Output selectors for scoreboard entries
  localparam int S_RD1 = 0;
  localparam int S_RD2 = 1;
  localparam int S_WBD = 2;
  localparam int S_WBV = 3;
  localparam int S_CNT = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic expect_out(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Advance to just after the next rising edge, where inputs are changed
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [31:0] alu,
                       input logic [31:0] rdat, input logic [4:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    RegWrite          = we;
    MemtoReg          = m2r;
    ALU_Result        = alu;
    ReadData          = rdat;
    Write_Destination = wd;
    Read_Reg1         = r1;
    Read_Reg2         = r2;
  endtask

  // Monitor: outputs are presented every cycle; compare all pending entries
  always @(negedge clk) begin
    logic [31:0] act;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      case (e.sel)
        S_RD1:   act = Read_Data1;
        S_RD2:   act = Read_Data2;
        S_WBD:   act = WB_Data;
        S_WBV:   act = {31'd0, WB_Valid};
        default: act = Retire_Count;
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    int wait_cnt;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

    // Reset for one edge, then sweep both read ports
    cyc();
    rst = 1'b0;
    for (int r = 0; r < 32; r++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(r), 5'(31 - r));
      expect_out($sformatf("reset_rd1_r%0d", r), S_RD1, 32'h0);
      expect_out($sformatf("reset_rd2_r%0d", 31 - r), S_RD2, 32'h0);
      if (r == 0) expect_out("reset_count", S_CNT, 32'h0);
      cyc();
    end

    // Mux and commit: ALU result to r5
    drive(1'b1, 1'b0, 32'h0000_1234, 32'hDEAD_BEEF, 5'd5, 5'd0, 5'd0);
    expect_out("mux_alu_wbdata", S_WBD, 32'h0000_1234);
    expect_out("mux_alu_wbvalid", S_WBV, 32'h1);
    cyc();
    // Load data to r6, read back r5
    drive(1'b1, 1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 5'd6, 5'd5, 5'd0);
    expect_out("mux_mem_wbdata", S_WBD, 32'hDEAD_BEEF);
    expect_out("r5_after_commit", S_RD1, 32'h0000_1234);
    expect_out("count_after_1", S_CNT, 32'd1);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd6, 5'd5);
    expect_out("r6_after_commit", S_RD1, 32'hDEAD_BEEF);
    expect_out("r5_port2", S_RD2, 32'h0000_1234);
    expect_out("count_after_2", S_CNT, 32'd2);
    cyc();

    // Register 0 write discarded
    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
    expect_out("r0_write_rd1", S_RD1, 32'h0);
    expect_out("r0_write_wbvalid", S_WBV, 32'h0);
    expect_out("r0_write_wbdata", S_WBD, 32'hFFFF_FFFF);
    cyc();
    // Disabled write to r7
    drive(1'b0, 1'b0, 32'h0000_0055, 32'h0, 5'd7, 5'd0, 5'd7);
    expect_out("r0_after_write", S_RD1, 32'h0);
    expect_out("count_after_r0", S_CNT, 32'd2);
    expect_out("disabled_wbvalid", S_WBV, 32'h0);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0);
    expect_out("r7_unchanged", S_RD1, 32'h0);
    expect_out("count_after_disabled", S_CNT, 32'd2);
    cyc();

    // Same-cycle read-after-write on r9
    drive(1'b1, 1'b0, 32'h0000_0011, 32'h0, 5'd9, 5'd0, 5'd0);
    cyc();
    drive(1'b1, 1'b0, 32'h0000_0022, 32'h0, 5'd9, 5'd9, 5'd9);
    expect_out("raw_commit_rd1", S_RD1, BYP ? 32'h22 : 32'h11);
    expect_out("raw_commit_rd2", S_RD2, BYP ? 32'h22 : 32'h11);
    expect_out("count_after_3", S_CNT, 32'd3);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
    expect_out("raw_next_rd1", S_RD1, 32'h22);
    expect_out("raw_next_rd2", S_RD2, 32'h22);
    expect_out("count_after_4", S_CNT, 32'd4);
    cyc();

    // Reset colliding with a commit to r3
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0000_ABCD, 32'h0, 5'd3, 5'd3, 5'd9);
    expect_out("coll_bypass_rd1", S_RD1, BYP ? 32'hABCD : 32'h0);
    expect_out("coll_pre_count", S_CNT, 32'd4);
    cyc();
    rst = 1'b0;
    expect_out("coll_r3_cleared_rd1", S_RD1, BYP ? 32'hABCD : 32'h0);
    expect_out("coll_r9_cleared", S_RD2, 32'h0);
    expect_out("coll_count_cleared", S_CNT, 32'd0);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
    expect_out("post_reset_r3", S_RD1, 32'h0000_ABCD);
    expect_out("post_reset_count", S_CNT, 32'd1);
    cyc();

    // Counter wrap via back-door preload
    force dut.Retire_Count = 32'hFFFF_FFFE;
    #1;
    release dut.Retire_Count;
    drive(1'b1, 1'b0, 32'h0000_0001, 32'h0, 5'd10, 5'd0, 5'd0);
    expect_out("wrap_preload", S_CNT, 32'hFFFF_FFFE);
    cyc();
    drive(1'b1, 1'b0, 32'h0000_0002, 32'h0, 5'd11, 5'd10, 5'd0);
    expect_out("wrap_max", S_CNT, 32'hFFFF_FFFF);
    expect_out("wrap_r10", S_RD1, 32'h1);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd11);
    expect_out("wrap_zero", S_CNT, 32'h0);
    expect_out("wrap_r11", S_RD2, 32'h2);

    // Drain the scoreboard with a bounded wait
    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending %0d expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
